// File: rtl/uart_cmd_wrapper.sv
// Assembles 3-byte commands from a UART receiver and issues single-byte responses to a UART transmitter.
// Optional inter-byte timeout is enabled by defining macro CMD_TIMEOUT_EN (limit set by TO_CYCLES).
module uart_cmd_wrapper #(
  parameter int unsigned TO_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  output logic [23:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  input  logic [7:0]  resp_data,
  output logic        trmt,
  output logic [7:0]  tx_data,
  input  logic        tx_done,
  output logic        resp_sent
);

  typedef enum logic [1:0] {HIGH, MID, LOW, FULL} rx_state_t;
  typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;

  rx_state_t rx_state;
  tx_state_t tx_state;
  logic      consume;
  logic      to_hit;

  // A byte is taken whenever one is waiting and a cmd slot is free; FULL applies backpressure.
  assign consume    = rx_rdy && (rx_state != FULL) && !rst;
  assign clr_rx_rdy = consume;

`ifdef CMD_TIMEOUT_EN
  localparam int unsigned TO_W = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;

  logic [TO_W-1:0] to_cnt;
  logic            partial;

  assign partial = (rx_state == MID) || (rx_state == LOW);
  assign to_hit  = partial && !consume && (to_cnt == TO_W'(TO_CYCLES - 1));

  // Idle-cycle counter between bytes of a partially received command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (!partial || consume || to_hit) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  // Receive FSM: the state names the cmd byte the next received byte fills.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= HIGH;
      cmd      <= 24'h000000;
      cmd_rdy  <= 1'b0;
    end else begin
      case (rx_state)
        HIGH: begin
          if (consume) begin
            cmd[23:16] <= rx_data;
            rx_state   <= MID;
          end
        end
        MID: begin
          if (consume) begin
            cmd[15:8] <= rx_data;
            rx_state  <= LOW;
          end else if (to_hit) begin
            rx_state <= HIGH;
          end
        end
        LOW: begin
          if (consume) begin
            cmd[7:0] <= rx_data;
            cmd_rdy  <= 1'b1;
            rx_state <= FULL;
          end else if (to_hit) begin
            rx_state <= HIGH;
          end
        end
        FULL: begin
          if (clr_cmd_rdy) begin
            cmd_rdy  <= 1'b0;
            rx_state <= HIGH;
          end
        end
      endcase
    end
  end

  // Transmit FSM: one response byte in flight at a time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state  <= TX_IDLE;
      tx_data   <= 8'h00;
      trmt      <= 1'b0;
      resp_sent <= 1'b0;
    end else begin
      trmt      <= 1'b0;
      resp_sent <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          if (send_resp) begin
            tx_data  <= resp_data;
            trmt     <= 1'b1;
            tx_state <= TX_BUSY;
          end
        end
        TX_BUSY: begin
          if (tx_done) begin
            resp_sent <= 1'b1;
            tx_state  <= TX_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/uart_cmd_wrapper.md
UART_CMD_WRAPPER -- requirements
Module: uart_cmd_wrapper

Interface
REQ-001 Parameter TO_CYCLES, default 1000000, inter-byte timeout in clk cycles (used only with CMD_TIMEOUT_EN).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 rx_rdy  input  1  level from UART receiver; a received byte is waiting on rx_data.
REQ-005 rx_data  input  8  received byte, valid while rx_rdy=1.
REQ-006 clr_rx_rdy  output  1  one-cycle pulse consuming the waiting byte.
REQ-007 cmd  output  24  assembled command, byte0 in [23:16], byte1 in [15:8], byte2 in [7:0].
REQ-008 cmd_rdy  output  1  level; cmd holds a complete command.
REQ-009 clr_cmd_rdy  input  1  pulse from command decoder; releases cmd.
REQ-010 send_resp  input  1  pulse requesting transmission of resp_data.
REQ-011 resp_data  input  8  response byte, sampled when send_resp=1.
REQ-012 trmt  output  1  one-cycle pulse starting the UART transmitter.
REQ-013 tx_data  output  8  byte to transmit; stable from trmt until tx_done.
REQ-014 tx_done  input  1  pulse from UART transmitter, byte shifted out.
REQ-015 resp_sent  output  1  one-cycle pulse, response fully transmitted.

Function
REQ-016 The receive FSM SHALL have states HIGH, MID, LOW, FULL, selecting which cmd byte the next rx byte fills.
REQ-017 In HIGH/MID/LOW with rx_rdy=1, the block SHALL pulse clr_rx_rdy combinationally that cycle and load rx_data into cmd[23:16]/[15:8]/[7:0] on the next edge.
REQ-018 The transitions SHALL be HIGH->MID->LOW on each consumed byte; LOW->FULL on the third byte, with cmd_rdy set on the same edge.
REQ-019 In FULL, clr_rx_rdy SHALL stay 0 (backpressure); cmd SHALL remain stable; further bytes wait in the receiver.
REQ-020 In FULL, clr_cmd_rdy=1 SHALL clear cmd_rdy and move to HIGH on the next edge; cmd retains its value until overwritten.
REQ-021 clr_cmd_rdy outside FULL SHALL be ignored.
REQ-022 A byte SHALL NOT be consumed in the cycle FULL->HIGH occurs; earliest consumption is the following cycle.
REQ-023 The transmit path SHALL have states TX_IDLE and TX_BUSY.
REQ-024 In TX_IDLE, send_resp=1 SHALL latch resp_data into tx_data, assert trmt for exactly one cycle on the next cycle, and enter TX_BUSY.
REQ-025 In TX_BUSY, tx_done=1 SHALL return to TX_IDLE and assert resp_sent for exactly one cycle on the next cycle.
REQ-026 send_resp during TX_BUSY SHALL be ignored, with no change to tx_data.
REQ-027 Receive and transmit paths SHALL operate independently; simultaneous rx_rdy, send_resp and tx_done SHALL each be handled as if alone.

Reset
REQ-028 Asserting rst SHALL immediately force: receive FSM=HIGH, cmd=24'h000000, cmd_rdy=0, transmit FSM=TX_IDLE, tx_data=8'h00, trmt=0, resp_sent=0, and the timeout counter=0.
REQ-029 Reset mid-command SHALL discard partial bytes; the first byte after reset SHALL be treated as byte0.
REQ-030 While rst=1, clr_rx_rdy SHALL be 0.

Configuration
REQ-031 With macro CMD_TIMEOUT_EN defined, a counter SHALL increment each cycle in MID or LOW without a consumed byte.
REQ-032 The counter SHALL clear on a consumed byte or on entering HIGH.
REQ-033 When the counter reaches TO_CYCLES-1, the FSM SHALL return to HIGH, discarding partial bytes, with cmd_rdy unaffected.
REQ-034 Without CMD_TIMEOUT_EN, no counter SHALL be built and MID/LOW SHALL wait indefinitely.

Verification
REQ-035 Bytes 8'h02, 8'h0D, 8'h00 at rx_rdy -> three clr_rx_rdy pulses; cmd=24'h020D00 and cmd_rdy=1 on the edge after the third byte.
REQ-036 cmd_rdy=1 and a 4th byte 8'h09 pending -> no clr_rx_rdy; after a clr_cmd_rdy pulse, cmd_rdy=0 next edge and 8'h09 consumed as byte0 one cycle later.
REQ-037 send_resp with resp_data=8'hA5 -> trmt one cycle later with tx_data=8'hA5; second send_resp (8'hEE) while busy ignored; tx_done -> resp_sent pulse next cycle.
REQ-038 rst asserted after two bytes -> all outputs at reset values; next three bytes 8'h07, 8'h00, 8'h00 -> cmd=24'h070000.
REQ-039 CMD_TIMEOUT_EN, TO_CYCLES=16: one byte, then 20 idle cycles, then 8'h01, 8'h02, 8'h03 -> cmd=24'h010203; without the macro, cmd=24'hXX0102 with byte0 from the first byte.
